audio_frame_sequencer: RTL

- Central timing scheduler for the 4-channel audio block.
- Divides the system clock down to a 512 Hz frame rate and steps an 8-step frame sequencer.
- Emits single-cycle enable strobes that sequence the channel datapaths:
  - length_tick at 256 Hz, consumed by every channel's length counter;
  - sweep_tick at 128 Hz, consumed by the channel-1 frequency sweep;
  - envelope_tick at 64 Hz, consumed by the volume envelopes.
- Replaces ad-hoc per-channel derived clocks, so all channel logic runs on one clock with enables.

---
 rtl/audio_frame_sequencer.sv | 88 ++++++++
 1 files changed

// File: rtl/audio_frame_sequencer.sv
// ============================================================================
// Module   : audio_frame_sequencer
// Purpose  : 512 Hz frame sequencer that emits single-cycle length, sweep and
//            envelope enables for the four audio channels.
// Revision : 1.0
// ============================================================================
`default_nettype none

module audio_frame_sequencer #(
    parameter int CLK_DIV = 32768,
    parameter int DIV_W   = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       sound_enable,
    output logic       frame_tick,
    output logic       length_tick,
    output logic       sweep_tick,
    output logic       envelope_tick,
    output logic [2:0] step
);

    localparam logic [DIV_W-1:0] C_PRESC_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] prescaler_q, prescaler_d;
    logic [2:0]       step_q, step_d;
    logic             frame_q, frame_d;
    logic             length_q, length_d;
    logic             sweep_q, sweep_d;
    logic             envelope_q, envelope_d;
    logic             w_advance;

    assign w_advance = (prescaler_q == C_PRESC_LAST);

    // Strobes default low every cycle, so a pulse can never outlive one clock
    // or survive a stall; the master enable clears regardless of ce.
    always_comb begin
        prescaler_d = prescaler_q;
        step_d      = step_q;
        frame_d     = 1'b0;
        length_d    = 1'b0;
        sweep_d     = 1'b0;
        envelope_d  = 1'b0;
        if (!sound_enable) begin
            prescaler_d = '0;
            step_d      = 3'd0;
        end else if (ce) begin
            if (w_advance) begin
                prescaler_d = '0;
                step_d      = step_q + 3'd1;
                frame_d     = 1'b1;
                length_d    = ~step_q[0];
                sweep_d     = (step_q[1:0] == 2'b10);
                envelope_d  = (step_q == 3'd7);
            end else begin
                prescaler_d = prescaler_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler_q <= '0;
            step_q      <= 3'd0;
            frame_q     <= 1'b0;
            length_q    <= 1'b0;
            sweep_q     <= 1'b0;
            envelope_q  <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            step_q      <= step_d;
            frame_q     <= frame_d;
            length_q    <= length_d;
            sweep_q     <= sweep_d;
            envelope_q  <= envelope_d;
        end
    end

    assign frame_tick    = frame_q;
    assign length_tick   = length_q;
    assign sweep_tick    = sweep_q;
    assign envelope_tick = envelope_q;
    assign step          = step_q;

endmodule

`default_nettype wire
